// File: rtl/i2c_sensor_target_if.sv
// i2c_sensor_target_if: open-drain I2C pin bundle between a bus master (or bus model) and
// the sensor target. sda_in is the resolved line level seen by the target.
interface i2c_sensor_target_if;
   logic scl_in;
   logic sda_in;
   logic sda_oe;

   modport master (output scl_in, output sda_in, input sda_oe);
   modport slave (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_sensor_target.sv
// i2c_sensor_target: I2C target returning a 16-bit sample on reads and latching 2-byte config
// writes. Define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL and SDA.
module i2c_sensor_target #(
   parameter logic [6:0]  TARGET_ADDR = 7'b1001000,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   i2c_sensor_target_if.slave  bus,
   input  logic [15:0]         sample_data,
   output logic [15:0]         cfg_data,
   output logic                cfg_valid,
   output logic                busy
);
   localparam logic [3:0] Hold = 4'(HOLD_CYCLES);

   typedef enum logic [2:0] {
      StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StWaitStop
   } state_e;

   logic [1:0] scl_sync, sda_sync;
   logic       scl_cur, sda_cur, scl_prev, sda_prev;

   // Idle bus is high, so synchronizers reset to 1 to avoid a false START at reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], bus.scl_in};
         sda_sync <= {sda_sync[0], bus.sda_in};
      end
   end

`ifdef I2C_GLITCH_FILTER_EN
   logic [1:0] scl_hist, sda_hist;
   logic       scl_filt, sda_filt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_hist <= 2'b11;
         sda_hist <= 2'b11;
         scl_filt <= 1'b1;
         sda_filt <= 1'b1;
      end else begin
         scl_hist <= {scl_hist[0], scl_sync[1]};
         sda_hist <= {sda_hist[0], sda_sync[1]};
         scl_filt <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) |
                     (scl_hist[0] & scl_hist[1]);
         sda_filt <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) |
                     (sda_hist[0] & sda_hist[1]);
      end
   end

   assign scl_cur = scl_filt;
   assign sda_cur = sda_filt;
`else
   assign scl_cur = scl_sync[1];
   assign sda_cur = sda_sync[1];
`endif

   logic scl_rise, scl_fall, start_det, stop_det;
   assign scl_rise  = scl_cur & ~scl_prev;
   assign scl_fall  = ~scl_cur & scl_prev;
   assign start_det = scl_cur & sda_prev & ~sda_cur;
   assign stop_det  = scl_cur & ~sda_prev & sda_cur;

   state_e      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d, hold_cnt_q, hold_cnt_d, cnt_n;
   logic [7:0]  shreg_q, shreg_d, stage_q, stage_d, rd_byte;
   logic [15:0] snap_q, snap_d, cfg_q, cfg_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic        rw_q, rw_d, byte_idx_q, byte_idx_d, ack_phase_q, ack_phase_d;
   logic        cfg_valid_q, cfg_valid_d, busy_q, busy_d, oe_q, oe_d;
   logic        pend_q, pend_d, pend_val_q, pend_val_d, pend_n, val_n;
   logic        sched, sched_val, cancel, rd_bit;

   assign rd_byte = byte_idx_q ? snap_q[7:0] : snap_q[15:8];
   assign rd_bit  = rd_byte[~bit_cnt_q[2:0]];

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      stage_d     = stage_q;
      snap_d      = snap_q;
      cfg_d       = cfg_q;
      byte_cnt_d  = byte_cnt_q;
      rw_d        = rw_q;
      byte_idx_d  = byte_idx_q;
      ack_phase_d = ack_phase_q;
      cfg_valid_d = 1'b0;
      busy_d      = busy_q;
      sched       = 1'b0;
      sched_val   = 1'b0;
      cancel      = 1'b0;
      if (start_det) begin
         state_d   = StAddr;
         bit_cnt_d = 4'd0;
         busy_d    = 1'b0;
         cancel    = 1'b1;
      end else if (stop_det) begin
         state_d = StIdle;
         busy_d  = 1'b0;
         cancel  = 1'b1;
      end else begin
         unique case (state_q)
            StIdle, StWaitStop: ;
            StAddr: if (scl_rise) begin
               shreg_d   = {shreg_q[6:0], sda_cur};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  if (shreg_q[6:0] == TARGET_ADDR) begin
                     state_d     = StAddrAck;
                     busy_d      = 1'b1;
                     rw_d        = sda_cur;
                     ack_phase_d = 1'b0;
                     if (sda_cur) snap_d = sample_data;
                  end else begin
                     state_d = StWaitStop;
                  end
               end
            end
            // First fall starts the ACK pulse, second fall ends it.
            StAddrAck: if (scl_fall) begin
               sched = 1'b1;
               if (!ack_phase_q) begin
                  sched_val   = 1'b1;
                  ack_phase_d = 1'b1;
               end else begin
                  ack_phase_d = 1'b0;
                  bit_cnt_d   = 4'd0;
                  if (rw_q) begin
                     state_d    = StRdByte;
                     byte_idx_d = 1'b0;
                     sched_val  = ~snap_q[15];
                  end else begin
                     state_d    = StWrByte;
                     byte_cnt_d = 2'd0;
                  end
               end
            end
            StWrByte: if (scl_rise) begin
               shreg_d   = {shreg_q[6:0], sda_cur};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  state_d     = StWrAck;
                  ack_phase_d = 1'b0;
               end
            end
            StWrAck: if (scl_fall) begin
               if (!ack_phase_q) begin
                  if (byte_cnt_q == 2'd2) begin
                     state_d = StWaitStop;
                  end else begin
                     sched       = 1'b1;
                     sched_val   = 1'b1;
                     ack_phase_d = 1'b1;
                     if (byte_cnt_q == 2'd0) stage_d = shreg_q;
                  end
               end else begin
                  sched       = 1'b1;
                  ack_phase_d = 1'b0;
                  bit_cnt_d   = 4'd0;
                  state_d     = StWrByte;
                  byte_cnt_d  = byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd1) begin
                     cfg_d       = {stage_q, shreg_q};
                     cfg_valid_d = 1'b1;
                  end
               end
            end
            StRdByte: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  // Released a 1 but the line reads 0: another driver owns the bus.
                  if (rd_bit && !sda_cur) state_d = StWaitStop;
               end else if (scl_fall) begin
                  sched = 1'b1;
                  if (bit_cnt_q == 4'd8) state_d = StRdAck;
                  else                   sched_val = ~rd_bit;
               end
            end
            StRdAck: if (scl_rise) begin
               if (!sda_cur) begin
                  byte_idx_d = ~byte_idx_q;
                  bit_cnt_d  = 4'd0;
                  state_d    = StRdByte;
               end else begin
                  state_d = StWaitStop;
               end
            end
         endcase
      end

      // Scheduled sda_oe changes become visible Hold cycles after the SCL-fall cycle.
      pend_n     = pend_q;
      val_n      = pend_val_q;
      cnt_n      = hold_cnt_q;
      oe_d       = oe_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      hold_cnt_d = hold_cnt_q;
      if (cancel) begin
         pend_d = 1'b0;
         oe_d   = 1'b0;
      end else begin
         if (sched) begin
            pend_n = 1'b1;
            val_n  = sched_val;
            cnt_n  = Hold;
         end
         if (pend_n) begin
            if (cnt_n <= 4'd1) begin
               oe_d   = val_n;
               pend_d = 1'b0;
            end else begin
               pend_d     = 1'b1;
               pend_val_d = val_n;
               hold_cnt_d = cnt_n - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         scl_prev    <= 1'b1;
         sda_prev    <= 1'b1;
         bit_cnt_q   <= 4'd0;
         hold_cnt_q  <= 4'd0;
         shreg_q     <= 8'h00;
         stage_q     <= 8'h00;
         snap_q      <= 16'h0000;
         cfg_q       <= 16'h0000;
         byte_cnt_q  <= 2'd0;
         rw_q        <= 1'b0;
         byte_idx_q  <= 1'b0;
         ack_phase_q <= 1'b0;
         cfg_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         oe_q        <= 1'b0;
         pend_q      <= 1'b0;
         pend_val_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         scl_prev    <= scl_cur;
         sda_prev    <= sda_cur;
         bit_cnt_q   <= bit_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         shreg_q     <= shreg_d;
         stage_q     <= stage_d;
         snap_q      <= snap_d;
         cfg_q       <= cfg_d;
         byte_cnt_q  <= byte_cnt_d;
         rw_q        <= rw_d;
         byte_idx_q  <= byte_idx_d;
         ack_phase_q <= ack_phase_d;
         cfg_valid_q <= cfg_valid_d;
         busy_q      <= busy_d;
         oe_q        <= oe_d;
         pend_q      <= pend_d;
         pend_val_q  <= pend_val_d;
      end
   end

   assign bus.sda_oe = oe_q;
   assign cfg_data   = cfg_q;
   assign cfg_valid  = cfg_valid_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_i2c_sensor_target.sv
// tb_i2c_sensor_target: bus-level master model driving the target, with a table of directed
// transfers, randomized transfers checked against a transaction-level model, and corner cases.
module tb_i2c_sensor_target;
   localparam logic [6:0] Addr = 7'h48;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        m_scl = 1'b1;
   logic        m_sda = 1'b1;
   logic [15:0] sample_data = 16'h0000;
   logic [15:0] cfg_data;
   logic        cfg_valid, busy;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          valid_cycles = 0;
   int          oe_cycles = 0;
   int          busy_cycles = 0;

   i2c_sensor_target_if bus ();
   assign bus.scl_in = m_scl;
   assign bus.sda_in = m_sda & ~bus.sda_oe;

   i2c_sensor_target dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sample_data(sample_data),
      .cfg_data   (cfg_data),
      .cfg_valid  (cfg_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cfg_valid) valid_cycles <= valid_cycles + 1;
      if (bus.sda_oe) oe_cycles <= oe_cycles + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   typedef struct {
      bit          rd;
      logic [6:0]  addr;
      int          n;
      logic [15:0] sample;
      logic [23:0] wdat;
      logic        exp_aack;
      logic [23:0] exp_rdat;
      logic [2:0]  exp_wack;
      logic [15:0] exp_cfg;
      int          exp_pulses;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input bit glitch, output logic got);
      cyc(8);
      m_sda = b;
      cyc(8);
      m_scl = 1'b1;
      cyc(3);
      if (glitch) begin
         m_scl = 1'b0;
         cyc(1);
         m_scl = 1'b1;
         cyc(2);
      end else begin
         cyc(3);
      end
      got = bus.sda_in;
      cyc(6);
      m_scl = 1'b0;
   endtask

   task automatic start_cond();
      m_sda = 1'b1;
      cyc(10);
      m_scl = 1'b1;
      cyc(10);
      m_sda = 1'b0;
      cyc(10);
      m_scl = 1'b0;
   endtask

   task automatic stop_cond();
      m_sda = 1'b0;
      cyc(10);
      m_scl = 1'b1;
      cyc(10);
      m_sda = 1'b1;
      cyc(10);
   endtask

   task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(b[i], (7 - i) == glitch_bit, s);
      send_bit(1'b1, 1'b0, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, 1'b0, s);
         b[i] = s;
      end
      send_bit(~ack, 1'b0, s);
   endtask

   task automatic xfer(input bit rd, input logic [6:0] addr, input int n, input logic [23:0] wdat,
                       output logic aack, output logic busy_mid, output logic [23:0] rdat,
                       output logic [2:0] wack);
      logic       a;
      logic [7:0] b;
      rdat = '0;
      wack = '0;
      start_cond();
      write_byte({addr, rd}, -1, aack);
      busy_mid = busy;
      if (aack) begin
         for (int i = 0; i < n; i++) begin
            if (rd) begin
               read_byte(i != n - 1, b);
               rdat[23 - 8 * i -: 8] = b;
            end else begin
               write_byte(wdat[23 - 8 * i -: 8], -1, a);
               wack[2 - i] = a;
               if (!a) break;
            end
         end
      end
      stop_cond();
   endtask

   task automatic run_vec(input vec_t v);
      logic        aack, busy_mid;
      logic [23:0] rdat;
      logic [2:0]  wack;
      int          vc0, oe0, bz0;
      sample_data = v.sample;
      vc0 = valid_cycles;
      oe0 = oe_cycles;
      bz0 = busy_cycles;
      xfer(v.rd, v.addr, v.n, v.wdat, aack, busy_mid, rdat, wack);
      check("addr_ack", aack, v.exp_aack);
      check("busy_after_addr", busy_mid, v.exp_aack);
      if (v.rd) check("read_bytes", rdat, v.exp_rdat);
      else      check("write_acks", wack, v.exp_wack);
      check("cfg_data", cfg_data, v.exp_cfg);
      check("cfg_valid_cycles", valid_cycles - vc0, v.exp_pulses);
      check("busy_after_stop", busy, 1'b0);
      check("sda_oe_after_stop", bus.sda_oe, 1'b0);
      if (!v.exp_aack) begin
         check("sda_oe_cycles_nomatch", oe_cycles - oe0, 0);
         check("busy_cycles_nomatch", busy_cycles - bz0, 0);
      end
   endtask

   // Transaction-level expectation: address match, alternating snapshot bytes, 2-byte commits.
   task automatic model(inout vec_t v, inout logic [15:0] mcfg);
      v.exp_aack   = (v.addr == Addr);
      v.exp_rdat   = '0;
      v.exp_wack   = '0;
      v.exp_pulses = 0;
      if (v.exp_aack) begin
         for (int i = 0; i < v.n; i++) begin
            if (v.rd) v.exp_rdat[23 - 8 * i -: 8] = (i % 2 == 0) ? v.sample[15:8] : v.sample[7:0];
            else      v.exp_wack[2 - i] = (i < 2);
         end
         if (!v.rd && v.n >= 2) begin
            mcfg         = v.wdat[23:8];
            v.exp_pulses = 1;
         end
      end
      v.exp_cfg = mcfg;
   endtask

   vec_t tbl[7];

   initial begin
      logic [15:0] mcfg;
      logic        a;
      logic [7:0]  b;
      int          oe0;
      vec_t        v;

      tbl[0] = '{1'b1, Addr, 2, 16'hA53C, 24'h0, 1'b1, 24'hA53C00, 3'b000, 16'h0000, 0};
      tbl[1] = '{1'b0, Addr, 3, 16'h0, 24'h123456, 1'b1, 24'h0, 3'b110, 16'h1234, 1};
      tbl[2] = '{1'b0, 7'h49, 2, 16'h0, 24'hABCD00, 1'b0, 24'h0, 3'b000, 16'h1234, 0};
      tbl[3] = '{1'b0, Addr, 1, 16'h0, 24'h770000, 1'b1, 24'h0, 3'b100, 16'h1234, 0};
      tbl[4] = '{1'b1, Addr, 3, 16'hBEEF, 24'h0, 1'b1, 24'hBEEFBE, 3'b000, 16'h1234, 0};
      tbl[5] = '{1'b0, Addr, 2, 16'h0, 24'h5AA500, 1'b1, 24'h0, 3'b110, 16'h5AA5, 1};
      tbl[6] = '{1'b1, 7'h11, 2, 16'h1111, 24'h0, 1'b0, 24'h0, 3'b000, 16'h5AA5, 0};

      cyc(3);
      check("reset_sda_oe", bus.sda_oe, 1'b0);
      check("reset_cfg_data", cfg_data, 16'h0000);
      check("reset_cfg_valid", cfg_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      rst = 1'b1;
      cyc(5);

      for (int i = 0; i < 7; i++) run_vec(tbl[i]);

      // Snapshot taken at address match survives a later change of sample_data.
      sample_data = 16'hA53C;
      start_cond();
      write_byte({Addr, 1'b1}, -1, a);
      check("snap_addr_ack", a, 1'b1);
      sample_data = 16'h1234;
      read_byte(1'b1, b);
      check("snap_byte0", b, 8'hA5);
      read_byte(1'b1, b);
      check("snap_byte1", b, 8'h3C);
      read_byte(1'b0, b);
      check("snap_wrap", b, 8'hA5);
      stop_cond();

      // Wrong address, then repeated START to the right one.
      oe0 = oe_cycles;
      start_cond();
      write_byte({7'h49, 1'b0}, -1, a);
      check("rs_wrong_addr_ack", a, 1'b0);
      check("rs_wrong_addr_oe", oe_cycles - oe0, 0);
      check("rs_wrong_addr_busy", busy, 1'b0);
      sample_data = 16'hC0DE;
      start_cond();
      write_byte({Addr, 1'b1}, -1, a);
      check("rs_addr_ack", a, 1'b1);
      read_byte(1'b1, b);
      check("rs_byte0", b, 8'hC0);
      read_byte(1'b0, b);
      check("rs_byte1", b, 8'hDE);
      stop_cond();
      check("rs_busy_after_stop", busy, 1'b0);

      // One-cycle SCL low pulse during the first address bit.
      sample_data = 16'hA53C;
      start_cond();
      write_byte({Addr, 1'b1}, 0, a);
`ifdef I2C_GLITCH_FILTER_EN
      check("glitch_addr_ack", a, 1'b1);
      read_byte(1'b1, b);
      check("glitch_byte0", b, 8'hA5);
      read_byte(1'b0, b);
      check("glitch_byte1", b, 8'h3C);
`else
      check("glitch_addr_ack", a, 1'b0);
`endif
      stop_cond();

      mcfg = 16'h5AA5;
      for (int k = 0; k < 16; k++) begin
         v.rd     = 1'($urandom_range(0, 1));
         v.addr   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : Addr;
         v.n      = int'($urandom_range(1, 3));
         v.sample = 16'($urandom);
         v.wdat   = 24'($urandom);
         model(v, mcfg);
         run_vec(v);
      end

      // Reset while the target is pulling SDA low in a data bit.
      sample_data = 16'h0000;
      start_cond();
      write_byte({Addr, 1'b1}, -1, a);
      check("rst_addr_ack", a, 1'b1);
      cyc(12);
      check("rst_oe_before", bus.sda_oe, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check("rst_oe_async", bus.sda_oe, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_cfg_data", cfg_data, 16'h0000);
      cyc(2);
      rst = 1'b1;
      cyc(2);
      stop_cond();
      v = '{1'b1, Addr, 2, 16'h0F5A, 24'h0, 1'b1, 24'h0F5A00, 3'b000, 16'h0000, 0};
      run_vec(v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/i2c_sensor_target.md
Name: i2c_sensor_target

Overview:
- I2C target (responder) for the sensor bus. Models one temperature or light sensor so the polling master can be verified and run on an FPGA without real devices.
- Answers reads with a 16-bit sample, MSB first.
- Accepts 2-byte configuration writes.
- Open-drain SDA only; never drives SCL (no clock stretching). One instance per bus address.

Parameters:
- TARGET_ADDR, 7'b1001000, 7-bit address this target ACKs.
- HOLD_CYCLES, 4, clk cycles from SCL-fall detection to any sda_oe change (data hold time); legal range 1..15.

Ports:
- clk  in  1  system clock, at least 20x SCL frequency.
- rst  in  1  asynchronous, active-low reset.
- scl_in  in  1  raw SCL pin level.
- sda_in  in  1  raw SDA pin level.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- sample_data  in  16  value returned on reads; snapshotted at address match.
- cfg_data  out  16  last complete 2-byte write.
- cfg_valid  out  1  one-cycle pulse when cfg_data updates.
- busy  out  1  high from address match to STOP or restart.

Behaviour:
- Reset values: rst low clears all state asynchronously. sda_oe=0, cfg_data=16'h0000, cfg_valid=0, busy=0, state=IDLE. Mid-transfer reset releases SDA immediately.
- Input path: scl_in and sda_in each pass through a 2-FF synchronizer plus a prev register.
- Edge and condition detection, all on synced signals:
  - SCL rise: prev=0, cur=1.
  - SCL fall: prev=1, cur=0.
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - START/STOP take priority over bit processing in the same cycle.
- Bit timing:
  - SDA is sampled on the SCL-rise cycle.
  - sda_oe changes are registered HOLD_CYCLES cycles after the SCL-fall cycle, then held until the next scheduled change.
  - A START or STOP detected while a change is pending cancels that change.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
  - Any state, START -> ADDR; bit count=0; sda_oe=0. Covers repeated start.
  - Any state, STOP -> IDLE; sda_oe=0; busy=0. A partial write byte is discarded.
  - ADDR: shifts 8 bits MSB first.
    - Bits[7:1]==TARGET_ADDR -> ADDR_ACK: drive ACK low for the 9th SCL period; busy=1; if R/W=1, snapshot sample_data.
    - Mismatch -> WAIT_STOP with no ACK; busy stays 0.
  - ADDR_ACK: on the SCL fall ending the ACK pulse, go to RD_BYTE (R/W=1) or WR_BYTE (R/W=0).
  - RD_BYTE: drives snapshot byte bit 7 first.
    - sda_oe = ~bit, so 1-bits release the line.
    - Byte index 0 = snapshot[15:8], index 1 = snapshot[7:0].
    - After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's bit on SCL rise.
    - ACK (0): toggle byte index, return to RD_BYTE. Reading past the LSB wraps to the MSB of the same snapshot; no new snapshot is taken.
    - NACK (1): go to WAIT_STOP.
  - WR_BYTE: shift 8 bits, then go to WR_ACK.
    - Byte 0 -> cfg_data[15:8] staging.
    - Byte 1 -> cfg_data[7:0] staging.
    - Byte 2 and later -> NACK (release), go to WAIT_STOP; cfg_data unchanged by extra bytes.
  - WR_ACK: drive ACK for bytes 0 and 1.
    - cfg_data is committed only after byte 1's ACK bit completes (SCL fall).
    - cfg_valid pulses for exactly one cycle at that commit.
  - WAIT_STOP: SDA released; waits for START or STOP.
- Arbitration: if the target releases SDA (sends 1) during RD_BYTE but samples 0 on SCL rise, it treats this as a lost bus and goes to WAIT_STOP.

Optional Feature:
- Macro I2C_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter sits after each synchronizer. A single-cycle glitch on scl_in or sda_in is ignored. Detection latency is +2 cycles, and sda_oe timing shifts by the same 2 cycles.
- Undefined: synchronizer only; no filter logic is synthesized.

Test Plan:
- Read, sample_data=16'hA53C, addr 0x48 R: target ACKs; bytes 0xA5 (master ACK) then 0x3C (master NACK); SDA released through STOP; busy 1->0 on STOP.
- Snapshot coherence: sample_data changes to 16'h1234 after the address ACK -> bus still returns 0xA5, 0x3C. A third ACKed read returns 0xA5.
- Write, addr 0x48 W, bytes 0x12, 0x34: both ACKed; cfg_valid single pulse; cfg_data=16'h1234. A third byte 0x56 is NACKed; cfg_data stays 16'h1234.
- Address 0x49 -> no ACK, sda_oe stays 0 for the whole transfer, busy=0. Repeated START then 0x48 R -> ACK and normal read.
- STOP after write byte 0x77 only -> no cfg_valid, cfg_data unchanged. rst low mid-RD_BYTE with sda_oe=1 -> sda_oe=0 the same instant, state IDLE.
- With I2C_GLITCH_FILTER_EN: a 1-cycle SCL low pulse during an address bit -> bit count unchanged, transfer completes correctly. Without the macro, the same pulse corrupts the address and the target does not ACK.
